hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
Hazard-detection and forwarding block for the 5-stage pipelined ARM datapath. It consumes the pipelined control flags produced by the controller (RegWriteM/W, MemtoRegE, PCSrcD/E/M/W, BranchTakenE) and returns the stall, flush and forwarding controls, including FlushE, which feeds the controller's D->E register clear.
- Internally tracks source and destination register numbers through E/M/W with the same register timing as the controller pipeline.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
CNT_WIDTH, 16, width of the stall and flush event counters (saturating)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
RA1D  input  4  Decode-stage source register 1 (Rn)
RA2D  input  4  Decode-stage source register 2 (Rm/Rd for STR)
WA3D  input  4  Decode-stage destination register
RegWriteM  input  1  Memory-stage register write (already condition-qualified)
RegWriteW  input  1  Writeback-stage register write
MemtoRegE  input  1  Execute-stage instruction is a load
PCSrcD  input  1  Decode-stage instruction writes PC
PCSrcE  input  1  Execute-stage instruction writes PC
PCSrcM  input  1  Memory-stage PC write (condition-qualified)
PCSrcW  input  1  Writeback-stage PC write
BranchTakenE  input  1  branch resolved taken in Execute
StallF  output  1  hold PC register
StallD  output  1  hold F->D register
FlushD  output  1  clear F->D register
FlushE  output  1  clear D->E register (datapath and controller)
ForwardAE  output  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM
ForwardBE  output  2  SrcB select, same encoding
StallCount  output  CNT_WIDTH  cycles with StallD=1, saturating
FlushCount  output  CNT_WIDTH  cycles with FlushE=1 or FlushD=1, saturating

Behaviour:
- Tracking registers: RA1E, RA2E, WA3E load from RA1D, RA2D, WA3D every rising edge. Synchronous clear to 0 when FlushE=1 at that edge, matching the controller D->E register. No enable.
- WA3M <= WA3E and WA3W <= WA3M every edge. No clear.
- Reset: all tracking registers and both counters go to 0 asynchronously. While reset=1, StallF, StallD, FlushD and FlushE are forced 0 and ForwardAE/BE forced 00.
- Forwarding (combinational, same cycle):
  - ForwardAE = 10 if RegWriteM & (RA1E==WA3M); else 01 if RegWriteW & (RA1E==WA3W); else 00. M has priority when both match.
  - ForwardBE is identical using RA2E.
- Load-use: LDRstall = MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)).
- PCWrPending = PCSrcD | PCSrcE | PCSrcM.
- StallD = LDRstall.
- StallF = LDRstall | PCWrPending.
- FlushE = LDRstall | BranchTakenE.
- FlushD = PCWrPending | PCSrcW | BranchTakenE.
- LDRstall and BranchTakenE together: FlushE=1 and StallD=1; FlushD=1 as well, so the branch wins and the stalled D instruction is discarded.
- A flushed E slot carries WA3E=0 with RegWriteE=0 (cleared in controller). No false forward results, because RegWriteM/W gate every match.
- Counters:
  - StallCount increments by 1 on each edge where StallD=1.
  - FlushCount increments by 1 on each edge where FlushE|FlushD=1; one increment per cycle even if both are set.
  - Both hold at 2^CNT_WIDTH-1 (no wrap). Neither counts while reset=1.
- Latency: all hazard outputs are combinational from inputs and current tracking registers. Tracking registers and counters update on the edge.

Test Plan:
- Reset: assert reset mid-run with StallCount=5 -> counters and WA3E/M/W read 0 immediately; StallF/StallD/FlushD/FlushE=0 and ForwardAE/BE=00 during reset.
- ALU->ALU forward: cycle n WA3D=3, next cycle RA1D=3. At n+2 RegWriteM=1 -> ForwardAE=10. If instead RegWriteM=0, RegWriteW=1 at n+3 -> ForwardAE=01. Both M and W match -> 10.
- Load-use: MemtoRegE=1, WA3E=4, RA2D=4 -> StallF=StallD=FlushE=1 for exactly one cycle. Next edge WA3E=0 and StallCount=1. After the stall, ForwardBE=01 when the load reaches W.
- Taken branch: BranchTakenE=1 for one cycle -> FlushD=FlushE=1, StallF=0, FlushCount+1. Next-edge RA1E/RA2E/WA3E=0.
- PC write (LDR PC): PCSrcD=1 then PCSrcE, PCSrcM, PCSrcW in successive cycles -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles, FlushCount+4.
- Saturation: CNT_WIDTH=4, hold LDR-use hazard 20 cycles -> StallCount stops at 15 and does not wrap.

Source files
------------

// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage pipelined ARM datapath.
// Produces stall/flush/forward controls and keeps saturating performance counters.
module hazard_unit #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           RA1D,
   input  logic [3:0]           RA2D,
   input  logic [3:0]           WA3D,
   input  logic                 RegWriteM,
   input  logic                 RegWriteW,
   input  logic                 MemtoRegE,
   input  logic                 PCSrcD,
   input  logic                 PCSrcE,
   input  logic                 PCSrcM,
   input  logic                 PCSrcW,
   input  logic                 BranchTakenE,
   output logic                 StallF,
   output logic                 StallD,
   output logic                 FlushD,
   output logic                 FlushE,
   output logic [1:0]           ForwardAE,
   output logic [1:0]           ForwardBE,
   output logic [CNT_WIDTH-1:0] StallCount,
   output logic [CNT_WIDTH-1:0] FlushCount
);

   logic [3:0] ra1_e;
   logic [3:0] ra2_e;
   logic [3:0] wa3_e;
   logic [3:0] wa3_m;
   logic [3:0] wa3_w;

   logic ldr_stall;
   logic pc_wr_pending;

   // Memory stage wins over writeback because it holds the younger result.
   function automatic logic [1:0] forward_select(input logic [3:0] ra);
      if (RegWriteM && (ra == wa3_m))
         return 2'b10;
      else if (RegWriteW && (ra == wa3_w))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      ldr_stall     = MemtoRegE && ((RA1D == wa3_e) || (RA2D == wa3_e));
      pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;
      StallF        = 1'b0;
      StallD        = 1'b0;
      FlushD        = 1'b0;
      FlushE        = 1'b0;
      ForwardAE     = 2'b00;
      ForwardBE     = 2'b00;
      if (!reset) begin
         StallD    = ldr_stall;
         StallF    = ldr_stall || pc_wr_pending;
         FlushE    = ldr_stall || BranchTakenE;
         FlushD    = pc_wr_pending || PCSrcW || BranchTakenE;
         ForwardAE = forward_select(ra1_e);
         ForwardBE = forward_select(ra2_e);
      end
   end

   // The E-stage copy is cleared together with the controller's D->E register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ra1_e <= 4'd0;
         ra2_e <= 4'd0;
         wa3_e <= 4'd0;
         wa3_m <= 4'd0;
         wa3_w <= 4'd0;
      end else begin
         if (FlushE) begin
            ra1_e <= 4'd0;
            ra2_e <= 4'd0;
            wa3_e <= 4'd0;
         end else begin
            ra1_e <= RA1D;
            ra2_e <= RA2D;
            wa3_e <= WA3D;
         end
         wa3_m <= wa3_e;
         wa3_w <= wa3_m;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallD && (StallCount != {CNT_WIDTH{1'b1}}))
            StallCount <= StallCount + 1'b1;
         if ((FlushD || FlushE) && (FlushCount != {CNT_WIDTH{1'b1}}))
            FlushCount <= FlushCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised scoreboard bench for hazard_unit with a stage-array reference model.
module tb_hazard_unit;

   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    RA1D = '0, RA2D = '0, WA3D = '0;
   logic          RegWriteM = 0, RegWriteW = 0, MemtoRegE = 0;
   logic          PCSrcD = 0, PCSrcE = 0, PCSrcM = 0, PCSrcW = 0, BranchTakenE = 0;
   logic          StallF, StallD, FlushD, FlushE;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [CW-1:0] StallCount, FlushCount;

   hazard_unit #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
      .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
      .BranchTakenE(BranchTakenE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      int stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b, stall_cnt, flush_cnt;
   } exp_t;

   exp_t exp_q[$];

   // Reference pipeline: index 0 = Execute, 1 = Memory, 2 = Writeback destinations.
   int dst[3];
   int src1_e, src2_e;
   int stall_n, flush_n;
   int checks, passed;
   bit done;

   function automatic int forward_of(input int ra);
      bit wr[3];
      wr[0] = 1'b0;
      wr[1] = RegWriteM;
      wr[2] = RegWriteW;
      for (int s = 1; s <= 2; s++)
         if (wr[s] && ra == dst[s])
            return (s == 1) ? 2 : 1;
      return 0;
   endfunction

   function automatic exp_t evaluate();
      exp_t e;
      bit ldr, pend;
      ldr  = MemtoRegE && (int'(RA1D) == dst[0] || int'(RA2D) == dst[0]);
      pend = PCSrcD || PCSrcE || PCSrcM;
      e.stall_cnt = stall_n;
      e.flush_cnt = flush_n;
      if (reset) begin
         e.stall_f = 0; e.stall_d = 0; e.flush_d = 0; e.flush_e = 0;
         e.fwd_a = 0; e.fwd_b = 0;
      end else begin
         e.stall_d = ldr;
         e.stall_f = ldr || pend;
         e.flush_e = ldr || BranchTakenE;
         e.flush_d = pend || PCSrcW || BranchTakenE;
         e.fwd_a   = forward_of(src1_e);
         e.fwd_b   = forward_of(src2_e);
      end
      return e;
   endfunction

   task automatic clearModel();
      dst = '{0, 0, 0};
      src1_e = 0; src2_e = 0;
      stall_n = 0; flush_n = 0;
   endtask

   // Account for the edge just taken using the inputs that were held across it.
   task automatic advanceModel();
      exp_t e;
      if (reset) return;
      e = evaluate();
      if (e.stall_d != 0 && stall_n < SAT) stall_n++;
      if ((e.flush_d != 0 || e.flush_e != 0) && flush_n < SAT) flush_n++;
      dst[2] = dst[1];
      dst[1] = dst[0];
      if (e.flush_e != 0) begin
         dst[0] = 0; src1_e = 0; src2_e = 0;
      end else begin
         dst[0] = WA3D; src1_e = RA1D; src2_e = RA2D;
      end
   endtask

   task automatic applyStimulus(
      input bit rst, input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] w3,
      input bit rwm, input bit rww, input bit m2r,
      input bit pd, input bit pe, input bit pm, input bit pw, input bit bt);
      @(posedge clk);
      advanceModel();
      #1;
      reset = rst; RA1D = a1; RA2D = a2; WA3D = w3;
      RegWriteM = rwm; RegWriteW = rww; MemtoRegE = m2r;
      PCSrcD = pd; PCSrcE = pe; PCSrcM = pm; PCSrcW = pw; BranchTakenE = bt;
      if (rst) clearModel();
      exp_q.push_back(evaluate());
   endtask

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
   endtask

   // Monitor: compare one expected record per cycle, away from the rising edge.
   initial begin
      exp_t e;
      int idle;
      idle = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            idle = 0;
            e = exp_q.pop_front();
            checkOutput("StallF",     int'(StallF),     e.stall_f);
            checkOutput("StallD",     int'(StallD),     e.stall_d);
            checkOutput("FlushD",     int'(FlushD),     e.flush_d);
            checkOutput("FlushE",     int'(FlushE),     e.flush_e);
            checkOutput("ForwardAE",  int'(ForwardAE),  e.fwd_a);
            checkOutput("ForwardBE",  int'(ForwardBE),  e.fwd_b);
            checkOutput("StallCount", int'(StallCount), e.stall_cnt);
            checkOutput("FlushCount", int'(FlushCount), e.flush_cnt);
         end else if (!done) begin
            idle++;
            if (idle > 50) begin
               checkOutput("monitor_timeout", idle, 0);
               idle = 0;
            end
         end
      end
   end

   initial begin
      int guard;
      checks = 0; passed = 0; done = 0;
      clearModel();
      #1 reset = 1'b1;

      // Reset held, then released with quiet inputs.
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 5, 6, 7, 1, 1, 1, 1, 1, 1, 1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // ALU->ALU forwarding: producer of r3, consumer, then M-only, W-only, both.
      applyStimulus(0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 3, 9, 8, 1, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 9, 0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0, 0);

      // Load-use on RA2D, then let the load drain to writeback.
      applyStimulus(0, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 4, 5, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 4, 5, 0, 1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 4, 5, 0, 1, 0, 0, 0, 0, 0, 0);

      // Taken branch, and load-use coinciding with a taken branch.
      applyStimulus(0, 2, 3, 6, 0, 0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 6, 2, 6, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 6, 2, 1, 0, 0, 1, 0, 0, 0, 0, 1);

      // PC write walking D->E->M->W.
      applyStimulus(0, 0, 0, 15, 0, 0, 0, 1, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 15, 0, 0, 0, 0, 1, 0, 0, 0);
      applyStimulus(0, 0, 0, 15, 0, 0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus(0, 0, 0, 15, 0, 0, 0, 0, 0, 0, 0, 0);

      // Sustained load-use on r0 to drive both counters into saturation.
      for (int i = 0; i < 20; i++)
         applyStimulus(0, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // Mid-run reset with nonzero counters, then random traffic.
      applyStimulus(1, 3, 3, 3, 1, 1, 1, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 99) == 0),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)),
                       1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 7) == 0));
      end

      done = 1;
      guard = 0;
      while (exp_q.size() > 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      #1;
      if (exp_q.size() > 0) checkOutput("drain_timeout", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
